// File: rtl/seq_stream_serializer.sv
// seq_stream_serializer: valid/ready word FIFO feeding an LSB-first bit shifter
// that drives the serial x input of the sequence detector, one bit per clock.
module seq_stream_serializer #(
  parameter int   WORD_BITS = 8,
  parameter int   DEPTH     = 4,
  parameter logic IDLE_BIT  = 1'b0
) (
  input  logic                   clock0,
  input  logic                   reset_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WORD_BITS-1:0]   in_data,
  output logic                   x,
  output logic                   x_valid,
  output logic                   word_start,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] fifo_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int BW = (WORD_BITS > 2) ? $clog2(WORD_BITS) : 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [BW-1:0] LAST_BIT = BW'(WORD_BITS - 1);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  state_t               r_state;
  state_t               w_state_nx;
  logic [WORD_BITS-1:0] r_mem [DEPTH];
  logic [PW-1:0]        r_wptr;
  logic [PW-1:0]        r_rptr;
  logic [CW-1:0]        r_count;
  logic [WORD_BITS-1:0] r_shreg;
  logic [WORD_BITS-1:0] w_shreg_nx;
  logic [BW-1:0]        r_bcnt;
  logic [BW-1:0]        w_bcnt_nx;
  logic                 r_x;
  logic                 w_x_nx;
  logic                 r_x_valid;
  logic                 w_x_valid_nx;
  logic                 r_word_start;
  logic                 w_word_start_nx;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_fifo_ne;
  logic [WORD_BITS-1:0] w_head;

  // in_ready looks only at the registered count so there is no path from in_valid or a pop
  assign in_ready   = (r_count != FULL_CNT) & reset_n;
  assign w_push     = in_valid & in_ready;
  assign w_fifo_ne  = (r_count != {CW{1'b0}});
  assign w_head     = r_mem[r_rptr];

  assign x          = r_x;
  assign x_valid    = r_x_valid;
  assign word_start = r_word_start;
  assign fifo_count = r_count;
  assign busy       = (r_state == ST_SHIFT) | w_fifo_ne;

  // FIFO storage; contents need no reset because the pointers are cleared
  always_ff @(posedge clock0) begin
    if (w_push) begin
      r_mem[r_wptr] <= in_data;
    end
  end

  // Next-state and next-output logic; x shows the bit chosen here one clock later
  always_comb begin
    w_state_nx      = r_state;
    w_pop           = 1'b0;
    w_shreg_nx      = r_shreg;
    w_bcnt_nx       = r_bcnt;
    w_x_nx          = r_x;
    w_x_valid_nx    = r_x_valid;
    w_word_start_nx = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_fifo_ne) begin
          w_pop           = 1'b1;
          w_shreg_nx      = w_head >> 1;
          w_x_nx          = w_head[0];
          w_x_valid_nx    = 1'b1;
          w_word_start_nx = 1'b1;
          w_bcnt_nx       = {BW{1'b0}};
          w_state_nx      = ST_SHIFT;
        end else begin
          w_x_nx       = IDLE_BIT;
          w_x_valid_nx = 1'b0;
        end
      end
      ST_SHIFT: begin
        if (r_bcnt != LAST_BIT) begin
          w_shreg_nx   = r_shreg >> 1;
          w_x_nx       = r_shreg[0];
          w_x_valid_nx = 1'b1;
          w_bcnt_nx    = r_bcnt + BW'(1);
        end else if (w_fifo_ne) begin
          // reload on the last bit so consecutive words leave no gap cycle
          w_pop           = 1'b1;
          w_shreg_nx      = w_head >> 1;
          w_x_nx          = w_head[0];
          w_x_valid_nx    = 1'b1;
          w_word_start_nx = 1'b1;
          w_bcnt_nx       = {BW{1'b0}};
        end else begin
          w_x_nx       = IDLE_BIT;
          w_x_valid_nx = 1'b0;
          w_bcnt_nx    = {BW{1'b0}};
          w_state_nx   = ST_IDLE;
        end
      end
      default: begin
        w_x_nx       = IDLE_BIT;
        w_x_valid_nx = 1'b0;
        w_bcnt_nx    = {BW{1'b0}};
        w_state_nx   = ST_IDLE;
      end
    endcase
  end

  // State, shifter, registered outputs and FIFO pointers/count
  always_ff @(posedge clock0) begin
    if (!reset_n) begin
      r_state      <= ST_IDLE;
      r_shreg      <= {WORD_BITS{1'b0}};
      r_bcnt       <= {BW{1'b0}};
      r_x          <= IDLE_BIT;
      r_x_valid    <= 1'b0;
      r_word_start <= 1'b0;
      r_wptr       <= {PW{1'b0}};
      r_rptr       <= {PW{1'b0}};
      r_count      <= {CW{1'b0}};
    end else begin
      r_state      <= w_state_nx;
      r_shreg      <= w_shreg_nx;
      r_bcnt       <= w_bcnt_nx;
      r_x          <= w_x_nx;
      r_x_valid    <= w_x_valid_nx;
      r_word_start <= w_word_start_nx;
      if (w_push) begin
        r_wptr <= r_wptr + PW'(1);
      end else begin
        r_wptr <= r_wptr;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + PW'(1);
      end else begin
        r_rptr <= r_rptr;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
